// File: rtl/ov7670_pkg.sv
// Shared OV7670 capture/display definitions: mode encodings, frame geometry, capture FSM states.
// Pure declarations; no latency or flow-control behaviour of its own.
package ov7670_pkg;

    localparam int DIM_W = 10;

    typedef enum logic [1:0] {
        MODE_VGA  = 2'b00,
        MODE_QVGA = 2'b01,
        MODE_CIF  = 2'b10,
        MODE_QCIF = 2'b11
    } cap_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ACTIVE
    } cap_state_t;

    localparam logic [DIM_W-1:0] VGA_W  = 10'd640;
    localparam logic [DIM_W-1:0] VGA_H  = 10'd480;
    localparam logic [DIM_W-1:0] QVGA_W = 10'd320;
    localparam logic [DIM_W-1:0] QVGA_H = 10'd240;
    localparam logic [DIM_W-1:0] CIF_W  = 10'd352;
    localparam logic [DIM_W-1:0] CIF_H  = 10'd288;
    localparam logic [DIM_W-1:0] QCIF_W = 10'd176;
    localparam logic [DIM_W-1:0] QCIF_H = 10'd144;

    function automatic logic [DIM_W-1:0] mode_width(input logic [1:0] mode);
        case (cap_mode_t'(mode))
            MODE_VGA:  return VGA_W;
            MODE_QVGA: return QVGA_W;
            MODE_CIF:  return CIF_W;
            default:   return QCIF_W;
        endcase
    endfunction

    function automatic logic [DIM_W-1:0] mode_height(input logic [1:0] mode);
        case (cap_mode_t'(mode))
            MODE_VGA:  return VGA_H;
            MODE_QVGA: return QVGA_H;
            MODE_CIF:  return CIF_H;
            default:   return QCIF_H;
        endcase
    endfunction

endpackage

// File: rtl/ov7670_sync_edge.sv
// Registers sensor VSYNC/HREF and flags their edges combinationally against the registered copy.
// Edge flags are valid in the cycle the new level is first sampled; no backpressure (sensor cannot stall).
module ov7670_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic vsync,
    input  logic href,
    output logic vsync_rise,
    output logic vsync_fall,
    output logic href_fall,
    output logic href_q
);

    logic vsync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            vsync_q <= vsync;
            href_q  <= href;
        end
    end

    assign vsync_rise = vsync & ~vsync_q;
    assign vsync_fall = ~vsync & vsync_q;
    assign href_fall  = ~href & href_q;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 byte-stream capture: pairs bytes into RGB565, generates frame-buffer write address/strobe, one-cycle latency.
// No backpressure: the sensor free-runs, so the frame buffer must accept one write every second cycle.
module ov7670_capture
    import ov7670_pkg::*;
#(
    parameter int H_STRIDE = 640,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic              capture_enable,
    input  logic [1:0]        capture_mode,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              wr_enable,
    output logic              frame_done,
    output logic              frame_error,
    output logic [7:0]        frame_count
);

    cap_state_t        state, state_next;
    logic [1:0]        mode_q;
    logic [DIM_W-1:0]  line, column, line_after, width, height;
    logic [ADDR_W-1:0] line_base;
    logic              phase, err_q;
    logic [7:0]        hi_byte;
    logic              vsync_rise, vsync_fall, href_fall, href_q;
    logic              active, frame_start, byte_vld, line_close, line_bad, pix_in_range, frame_bad;

    ov7670_sync_edge u_sync_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .vsync      (vsync),
        .href       (href),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall),
        .href_fall  (href_fall),
        .href_q     (href_q)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (vsync && capture_enable) state_next = ST_SYNC;
            ST_SYNC:   if (!capture_enable) state_next = ST_IDLE;
                       else if (vsync_fall) state_next = ST_ACTIVE;
            ST_ACTIVE: if (vsync_rise) state_next = capture_enable ? ST_SYNC : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // A line still open when VSYNC rises is closed on the same edge as the frame.
    assign active       = (state == ST_ACTIVE);
    assign frame_start  = (state == ST_SYNC) && capture_enable && vsync_fall;
    assign width        = mode_width(mode_q);
    assign height       = mode_height(mode_q);
    assign byte_vld     = active && href && !vsync_rise;
    assign line_close   = active && (href_fall || (vsync_rise && href_q));
    assign line_bad     = phase || (column != width);
    assign pix_in_range = (column < width) && (line < height);
    assign line_after   = (line_close && line != '1) ? line + 1'b1 : line;
    assign frame_bad    = err_q || (line_close && line_bad) || (line_after != height);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            mode_q      <= 2'b00;
            line        <= '0;
            column      <= '0;
            line_base   <= '0;
            phase       <= 1'b0;
            err_q       <= 1'b0;
            hi_byte     <= 8'h00;
            wr_addr     <= '0;
            wr_data     <= 16'h0000;
            wr_enable   <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            frame_count <= 8'h00;
        end else begin
            state       <= state_next;
            wr_enable   <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            if (frame_start) begin
                mode_q    <= capture_mode;
                line      <= '0;
                column    <= '0;
                line_base <= '0;
                phase     <= 1'b0;
                err_q     <= 1'b0;
            end
            if (byte_vld) begin
                phase <= ~phase;
                if (!phase) begin
                    hi_byte <= d;
                end else if (pix_in_range) begin
                    wr_enable <= 1'b1;
                    wr_addr   <= line_base + {{(ADDR_W-DIM_W){1'b0}}, column};
                    wr_data   <= {hi_byte, d};
                    column    <= column + 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (line_close) begin
                line      <= line_after;
                line_base <= line_base + ADDR_W'(H_STRIDE);
                column    <= '0;
                phase     <= 1'b0;
                if (line_bad) err_q <= 1'b1;
            end
            if (active && vsync_rise) begin
                frame_done  <= 1'b1;
                frame_error <= frame_bad;
                frame_count <= frame_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture: drives byte-level frames and compares write/frame results with hand-derived values.
module tb_ov7670_capture;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vsync = 1'b1;
    logic        href = 1'b0;
    logic [7:0]  d = 8'h00;
    logic        capture_enable = 1'b1;
    logic [1:0]  capture_mode = 2'b11;
    logic [18:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_enable;
    logic        frame_done;
    logic        frame_error;
    logic [7:0]  frame_count;

    int          n_chk = 0;
    int          n_bad = 0;
    logic [18:0] wa_q[$];
    logic [15:0] wd_q[$];
    int          done_cnt = 0;
    logic        err_seen = 1'b0;

    ov7670_capture #(.H_STRIDE(640), .ADDR_W(19)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .vsync          (vsync),
        .href           (href),
        .d              (d),
        .capture_enable (capture_enable),
        .capture_mode   (capture_mode),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_enable      (wr_enable),
        .frame_done     (frame_done),
        .frame_error    (frame_error),
        .frame_count    (frame_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_enable) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
        if (frame_done) begin
            done_cnt = done_cnt + 1;
            err_seen = frame_error;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic put_byte(input logic [7:0] b);
        @(negedge clk);
        href = 1'b1;
        d    = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            href = 1'b0;
        end
    endtask

    // Pixel (line l, column c) carries bytes 0xF8^l, 0x1F^c.
    task automatic send_line(input int npix, input int extra, input int lidx);
        for (int i = 0; i < npix; i++) begin
            put_byte(8'hF8 ^ 8'(lidx));
            put_byte(8'h1F ^ 8'(i));
        end
        for (int i = 0; i < extra; i++) put_byte(8'hAA);
        idle(3);
    endtask

    task automatic frame_begin();
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
        idle(4);
        @(negedge clk);
        vsync = 1'b0;
        idle(3);
    endtask

    task automatic frame_end();
        @(negedge clk);
        href  = 1'b0;
        vsync = 1'b1;
        idle(4);
    endtask

    task automatic send_frame(input int nlines, input int npix);
        frame_begin();
        for (int l = 0; l < nlines; l++) send_line(npix, 0, l);
        frame_end();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_wr_enable", 32'(wr_enable), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_error", 32'(frame_error), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        reset_n = 1'b1;

        // Full well-formed QCIF frame
        send_frame(144, 176);
        chk("qcif_nwr", 32'(wa_q.size()), 32'd25344);
        chk("qcif_first_addr", 32'(wa_q[0]), 32'd0);
        chk("qcif_first_data", 32'(wd_q[0]), 32'hF81F);
        chk("qcif_last_addr", 32'(wa_q[$]), 32'd91695);
        chk("qcif_last_data", 32'(wd_q[$]), 32'h77B0);
        chk("qcif_done", 32'(done_cnt), 32'd1);
        chk("qcif_err", 32'(err_seen), 32'd0);
        chk("qcif_count", 32'(frame_count), 32'd1);

        // Reset in the middle of a VGA frame
        capture_mode = 2'b00;
        frame_begin();
        send_line(640, 0, 0);
        send_line(640, 0, 1);
        for (int i = 0; i < 10; i++) begin
            put_byte(8'h12);
            put_byte(8'h34);
        end
        @(posedge clk);
        #2;
        chk("pre_rst_wr_enable", 32'(wr_enable), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_wr_enable", 32'(wr_enable), 32'd0);
        chk("async_rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("async_rst_count", 32'(frame_count), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            put_byte(8'h12);
            put_byte(8'h34);
        end
        idle(3);
        send_line(640, 0, 3);
        frame_end();
        chk("rst_frame_nwr", 32'(wa_q.size()), 32'd0);
        chk("rst_frame_done", 32'(done_cnt), 32'd0);
        capture_mode = 2'b11;
        send_frame(2, 176);
        chk("post_rst_nwr", 32'(wa_q.size()), 32'd352);
        chk("post_rst_first_addr", 32'(wa_q[0]), 32'd0);
        chk("post_rst_count", 32'(frame_count), 32'd1);
        chk("post_rst_err", 32'(err_seen), 32'd1);

        // Over-long line: 180 pixels on line 1
        frame_begin();
        send_line(176, 0, 0);
        send_line(180, 0, 1);
        send_line(176, 0, 2);
        frame_end();
        chk("long_nwr", 32'(wa_q.size()), 32'd528);
        chk("long_line1_last", 32'(wa_q[351]), 32'd815);
        chk("long_line2_first", 32'(wa_q[352]), 32'd1280);
        chk("long_last_addr", 32'(wa_q[$]), 32'd1455);
        chk("long_err", 32'(err_seen), 32'd1);
        chk("long_count", 32'(frame_count), 32'd2);

        // Odd byte count: HREF drops after 3 bytes
        frame_begin();
        send_line(1, 1, 0);
        send_line(176, 0, 1);
        frame_end();
        chk("odd_nwr", 32'(wa_q.size()), 32'd177);
        chk("odd_first_data", 32'(wd_q[0]), 32'hF81F);
        chk("odd_next_addr", 32'(wa_q[1]), 32'd640);
        chk("odd_next_data", 32'(wd_q[1]), 32'hF91F);
        chk("odd_err", 32'(err_seen), 32'd1);

        // capture_enable dropped mid-frame
        frame_begin();
        send_line(176, 0, 0);
        send_line(176, 0, 1);
        capture_enable = 1'b0;
        send_line(176, 0, 2);
        send_line(176, 0, 3);
        frame_end();
        chk("en_drop_nwr", 32'(wa_q.size()), 32'd704);
        chk("en_drop_done", 32'(done_cnt), 32'd1);
        chk("en_drop_count", 32'(frame_count), 32'd4);
        send_frame(2, 176);
        chk("disabled_nwr", 32'(wa_q.size()), 32'd0);
        chk("disabled_done", 32'(done_cnt), 32'd0);

        // Mode change VGA->QVGA mid-frame
        capture_enable = 1'b1;
        capture_mode   = 2'b00;
        frame_begin();
        send_line(400, 0, 0);
        capture_mode = 2'b01;
        send_line(400, 0, 1);
        frame_end();
        chk("mode_vga_nwr", 32'(wa_q.size()), 32'd800);
        chk("mode_vga_last", 32'(wa_q[$]), 32'd1039);
        send_frame(1, 330);
        chk("mode_qvga_nwr", 32'(wa_q.size()), 32'd320);
        chk("mode_qvga_last", 32'(wa_q[$]), 32'd319);
        chk("mode_qvga_err", 32'(err_seen), 32'd1);
        chk("mode_qvga_count", 32'(frame_count), 32'd6);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
